game_input_arbiter: RTL and testbench
=====================================

Name: game_input_arbiter

Overview:
- Sits between the raw player inputs and the game core: board switches SW1/SW2 and decoded Dualshock buttons (flap, start).
- Debounces every source, arbitrates flap ownership between board and pad, and emits a level plus a one-cycle flap strobe.
- Converts a sustained reset/start hold into a fixed-length, active-low game reset pulse.
- Replaces the ad-hoc OR of button sources that currently drives the game core's Button and sys_reset inputs.

Parameters:
- DEBOUNCE_CYCLES, 252000: cycles an input must be stable before it is accepted (10 ms at 25.2 MHz).
- RESET_HOLD_CYCLES, 25200000: cycles the reset request must be held before a reset is issued (1 s).
- RESET_PULSE_CYCLES, 16: length of the game_reset_n low pulse.

Ports:
- Clk  in  1  pixel clock; all logic in this single domain.
- sys_reset  in  1  synchronous, active-high reset.
- sw_flap  in  1  board flap switch, active-high, asynchronous.
- sw_reset  in  1  board reset switch, active-high, asynchronous.
- pad_valid  in  1  1 = controller present and data valid.
- pad_flap  in  1  decoded pad flap button, active-high.
- pad_start  in  1  decoded pad start button, active-high.
- flap_n  out  1  active-low flap level to the game core.
- flap_pulse  out  1  one-cycle strobe on flap acceptance.
- game_reset_n  out  1  active-low game reset pulse.
- owner  out  2  0 = none, 1 = board, 2 = pad.
- reset_pending  out  1  high while a reset hold is counting.

Behaviour:
- sys_reset:
  - All synchronisers, debounced values and counters go to 0; both FSMs go to their idle states.
  - Outputs: flap_n=1, flap_pulse=0, game_reset_n=1, owner=0, reset_pending=0.
  - sys_reset asserted mid-count or mid-pulse aborts immediately to these values.
- Input conditioning:
  - pad_flap and pad_start are ANDed with pad_valid before synchronisation, so a missing pad reads as released.
  - Each of the 4 inputs passes through a 2-flop synchroniser, then a debouncer.
  - Debouncer: counter clears whenever the synced value equals the stable value. Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1 the stable value takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the stable value.
  - Latency from a clean pin edge to the debounced change is DEBOUNCE_CYCLES+2 cycles.
- Flap FSM (states F_IDLE, F_BOARD, F_PAD), all outputs registered:
  - F_IDLE: a debounced rising edge of sw_flap moves to F_BOARD; otherwise a debounced rising edge of pad_flap moves to F_PAD. Simultaneous edges go to F_BOARD.
  - Levels already held on entry to F_IDLE are ignored; only fresh rising edges are accepted.
  - F_BOARD: stays while db_sw_flap=1; on its release returns to F_IDLE. F_PAD behaves the same with db_pad_flap. The non-owning source is ignored.
  - flap_n=0 and owner=1/2 while in F_BOARD/F_PAD; flap_pulse=1 for exactly the first cycle after entry.
  - Pin-to-flap_n latency is DEBOUNCE_CYCLES+3 cycles.
- Reset FSM (states R_IDLE, R_COUNT, R_PULSE, R_WAIT); req = db_sw_reset | db_pad_start:
  - R_IDLE: req=1 clears hold_cnt and moves to R_COUNT.
  - R_COUNT: reset_pending=1 and hold_cnt increments each cycle. req=0 returns to R_IDLE with no pulse. hold_cnt==RESET_HOLD_CYCLES-1 moves to R_PULSE.
  - R_PULSE: game_reset_n=0 for exactly RESET_PULSE_CYCLES cycles, then R_WAIT.
  - R_WAIT: waits for req=0, then R_IDLE. Holding past one pulse never produces a second pulse.
  - While in R_PULSE the Flap FSM is forced to F_IDLE with flap_n=1; no flap_pulse is produced until R_WAIT.
- Counter widths are $clog2 of the relevant parameter; counters saturate and never wrap.

Test Plan (DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=16, RESET_PULSE_CYCLES=3):
- sys_reset 2 cycles, inputs 0 -> flap_n=1, game_reset_n=1, owner=0, flap_pulse=0 throughout.
- sw_flap 1-cycle and 3-cycle glitches -> flap_n stays 1. sw_flap held high -> flap_n=0 and flap_pulse=1 for 1 cycle, 7 cycles after the edge, with owner=1.
- pad_flap and sw_flap rise in the same cycle -> owner=1. Release sw_flap while pad_flap is still held -> owner returns to 0 and no pad flap_pulse occurs until pad_flap is released and re-pressed.
- pad_valid=0 with pad_flap=1 and pad_start=1 -> no flap, no reset_pending.
- sw_reset held 10 cycles post-debounce, then released -> reset_pending high for 10 cycles, game_reset_n stays 1.
- pad_start held 40 cycles -> game_reset_n low for exactly 3 cycles after 16 counted cycles, a single pulse only. A flap during the pulse produces no flap_pulse. sys_reset asserted mid-pulse -> game_reset_n=1 on the next cycle.

Source files
------------

// File: rtl/game_input_arbiter.sv
// game_input_arbiter
// Conditions the board switches and decoded pad buttons, arbitrates flap
// ownership between board and pad, and turns a long reset/start hold into a
// fixed-length active-low game reset pulse. Single clock domain (Clk).
module game_input_arbiter #(
   parameter int DEBOUNCE_CYCLES    = 252000,
   parameter int RESET_HOLD_CYCLES  = 25200000,
   parameter int RESET_PULSE_CYCLES = 16
) (
   input  logic       Clk,
   input  logic       sys_reset,
   input  logic       sw_flap,
   input  logic       sw_reset,
   input  logic       pad_valid,
   input  logic       pad_flap,
   input  logic       pad_start,
   output logic       flap_n,
   output logic       flap_pulse,
   output logic       game_reset_n,
   output logic [1:0] owner,
   output logic       reset_pending
);

   // Counter widths; a parameter of 1 still needs a 1-bit counter.
   localparam int DB_W    = (DEBOUNCE_CYCLES    > 1) ? $clog2(DEBOUNCE_CYCLES)    : 1;
   localparam int HOLD_W  = (RESET_HOLD_CYCLES  > 1) ? $clog2(RESET_HOLD_CYCLES)  : 1;
   localparam int PULSE_W = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;

   localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RESET_PULSE_CYCLES - 1);

   // Input vector bit positions
   localparam int N_IN          = 4;
   localparam int IDX_SW_FLAP   = 0;
   localparam int IDX_SW_RESET  = 1;
   localparam int IDX_PAD_FLAP  = 2;
   localparam int IDX_PAD_START = 3;

   localparam logic [1:0] OWNER_NONE  = 2'd0;
   localparam logic [1:0] OWNER_BOARD = 2'd1;
   localparam logic [1:0] OWNER_PAD   = 2'd2;

   typedef enum logic [1:0] {
      F_IDLE  = 2'd0,
      F_BOARD = 2'd1,
      F_PAD   = 2'd2
   } flap_state_t;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_COUNT = 2'd1,
      R_PULSE = 2'd2,
      R_WAIT  = 2'd3
   } rst_state_t;

   // ------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------
   logic [N_IN-1:0] raw_in;
   logic [N_IN-1:0] sync1_q;
   logic [N_IN-1:0] sync2_q;
   logic [N_IN-1:0] db;

   // A missing pad reads as all buttons released.
   assign raw_in[IDX_SW_FLAP]   = sw_flap;
   assign raw_in[IDX_SW_RESET]  = sw_reset;
   assign raw_in[IDX_PAD_FLAP]  = pad_flap  & pad_valid;
   assign raw_in[IDX_PAD_START] = pad_start & pad_valid;

   // Two-flop synchroniser for all asynchronous sources.
   always_ff @(posedge Clk) begin
      if (sys_reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_IN; gi++) begin : g_debounce
         logic [DB_W-1:0] cnt_q;
         logic            stable_q;

         // Accept a new level only after it has differed from the stable
         // value for DEBOUNCE_CYCLES consecutive cycles.
         always_ff @(posedge Clk) begin
            if (sys_reset) begin
               cnt_q    <= '0;
               stable_q <= 1'b0;
            end else if (sync2_q[gi] == stable_q) begin
               cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
               stable_q <= sync2_q[gi];
               cnt_q    <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         assign db[gi] = stable_q;
      end
   endgenerate

   logic db_sw_flap;
   logic db_pad_flap;
   logic req;

   assign db_sw_flap  = db[IDX_SW_FLAP];
   assign db_pad_flap = db[IDX_PAD_FLAP];
   assign req         = db[IDX_SW_RESET] | db[IDX_PAD_START];

   // Previous debounced flap levels; tracking continuously means a level
   // already held when the FSM returns to idle never looks like an edge.
   logic sw_flap_prev_q;
   logic pad_flap_prev_q;
   logic sw_rise;
   logic pad_rise;

   // Edge-detect history for the two flap sources.
   always_ff @(posedge Clk) begin
      if (sys_reset) begin
         sw_flap_prev_q  <= 1'b0;
         pad_flap_prev_q <= 1'b0;
      end else begin
         sw_flap_prev_q  <= db_sw_flap;
         pad_flap_prev_q <= db_pad_flap;
      end
   end

   assign sw_rise  = db_sw_flap  & ~sw_flap_prev_q;
   assign pad_rise = db_pad_flap & ~pad_flap_prev_q;

   // ------------------------------------------------------------------
   // Reset request FSM
   // ------------------------------------------------------------------
   rst_state_t         rst_state_q, rst_state_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
   logic               game_reset_n_q, game_reset_n_d;
   logic               reset_pending_q, reset_pending_d;

   // Reset FSM next state and registered-output precompute.
   always_comb begin
      rst_state_d = rst_state_q;
      hold_cnt_d  = hold_cnt_q;
      pulse_cnt_d = pulse_cnt_q;
      case (rst_state_q)
         R_IDLE: begin
            if (req) begin
               hold_cnt_d  = '0;
               rst_state_d = R_COUNT;
            end
         end
         R_COUNT: begin
            if (!req) begin
               rst_state_d = R_IDLE;
            end else if (hold_cnt_q == HOLD_LAST) begin
               pulse_cnt_d = '0;
               rst_state_d = R_PULSE;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         R_PULSE: begin
            if (pulse_cnt_q == PULSE_LAST) begin
               rst_state_d = R_WAIT;
            end else begin
               pulse_cnt_d = pulse_cnt_q + 1'b1;
            end
         end
         R_WAIT: begin
            // One pulse per hold: wait for a full release first.
            if (!req) begin
               rst_state_d = R_IDLE;
            end
         end
         default: begin
            rst_state_d = R_IDLE;
         end
      endcase
      reset_pending_d = (rst_state_d == R_COUNT);
      game_reset_n_d  = (rst_state_d != R_PULSE);
   end

   // Reset FSM state, counters and outputs.
   always_ff @(posedge Clk) begin
      if (sys_reset) begin
         rst_state_q     <= R_IDLE;
         hold_cnt_q      <= '0;
         pulse_cnt_q     <= '0;
         game_reset_n_q  <= 1'b1;
         reset_pending_q <= 1'b0;
      end else begin
         rst_state_q     <= rst_state_d;
         hold_cnt_q      <= hold_cnt_d;
         pulse_cnt_q     <= pulse_cnt_d;
         game_reset_n_q  <= game_reset_n_d;
         reset_pending_q <= reset_pending_d;
      end
   end

   // ------------------------------------------------------------------
   // Flap ownership FSM
   // ------------------------------------------------------------------
   flap_state_t flap_state_q, flap_state_d;
   logic        flap_n_q, flap_n_d;
   logic        flap_pulse_q, flap_pulse_d;
   logic [1:0]  owner_q, owner_d;

   // Flap FSM next state; board wins a simultaneous press, and a game
   // reset pulse holds the FSM idle so no flap is seen during it.
   always_comb begin
      flap_state_d = flap_state_q;
      case (flap_state_q)
         F_IDLE: begin
            if (sw_rise) begin
               flap_state_d = F_BOARD;
            end else if (pad_rise) begin
               flap_state_d = F_PAD;
            end
         end
         F_BOARD: begin
            if (!db_sw_flap) begin
               flap_state_d = F_IDLE;
            end
         end
         F_PAD: begin
            if (!db_pad_flap) begin
               flap_state_d = F_IDLE;
            end
         end
         default: begin
            flap_state_d = F_IDLE;
         end
      endcase
      if (rst_state_d == R_PULSE) begin
         flap_state_d = F_IDLE;
      end

      flap_n_d     = (flap_state_d == F_IDLE);
      flap_pulse_d = (flap_state_q == F_IDLE) && (flap_state_d != F_IDLE);
      case (flap_state_d)
         F_BOARD: owner_d = OWNER_BOARD;
         F_PAD:   owner_d = OWNER_PAD;
         default: owner_d = OWNER_NONE;
      endcase
   end

   // Flap FSM state and registered outputs.
   always_ff @(posedge Clk) begin
      if (sys_reset) begin
         flap_state_q <= F_IDLE;
         flap_n_q     <= 1'b1;
         flap_pulse_q <= 1'b0;
         owner_q      <= OWNER_NONE;
      end else begin
         flap_state_q <= flap_state_d;
         flap_n_q     <= flap_n_d;
         flap_pulse_q <= flap_pulse_d;
         owner_q      <= owner_d;
      end
   end

   assign flap_n        = flap_n_q;
   assign flap_pulse    = flap_pulse_q;
   assign owner         = owner_q;
   assign game_reset_n  = game_reset_n_q;
   assign reset_pending = reset_pending_q;

endmodule

// File: tb/tb_game_input_arbiter.sv
// Directed testbench for game_input_arbiter with short parameters
// (debounce 4, hold 16, pulse 3). Inputs change 1 time unit after a rising
// edge; outputs are checked at the same point.
module tb_game_input_arbiter;

   logic       Clk;
   logic       sys_reset;
   logic       sw_flap;
   logic       sw_reset;
   logic       pad_valid;
   logic       pad_flap;
   logic       pad_start;
   logic       flap_n;
   logic       flap_pulse;
   logic       game_reset_n;
   logic [1:0] owner;
   logic       reset_pending;

   int total;
   int bad;

   game_input_arbiter #(
      .DEBOUNCE_CYCLES    (4),
      .RESET_HOLD_CYCLES  (16),
      .RESET_PULSE_CYCLES (3)
   ) dut (
      .Clk           (Clk),
      .sys_reset     (sys_reset),
      .sw_flap       (sw_flap),
      .sw_reset      (sw_reset),
      .pad_valid     (pad_valid),
      .pad_flap      (pad_flap),
      .pad_start     (pad_start),
      .flap_n        (flap_n),
      .flap_pulse    (flap_pulse),
      .game_reset_n  (game_reset_n),
      .owner         (owner),
      .reset_pending (reset_pending)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      sys_reset = 1'b1;
      sw_flap   = 1'b0;
      sw_reset  = 1'b0;
      pad_valid = 1'b1;
      pad_flap  = 1'b0;
      pad_start = 1'b0;

      // Reset state, held two cycles and one cycle after release
      for (int i = 0; i < 3; i++) begin
         step(1);
         if (i == 1) sys_reset = 1'b0;
         chk("rst_flap_n", 32'(flap_n), 1);
         chk("rst_flap_pulse", 32'(flap_pulse), 0);
         chk("rst_game_reset_n", 32'(game_reset_n), 1);
         chk("rst_owner", 32'(owner), 0);
         chk("rst_pending", 32'(reset_pending), 0);
      end
      $display("txn reset: done");

      // One-cycle glitch on sw_flap
      sw_flap = 1'b1;
      step(1);
      sw_flap = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("glitch1_flap_n", 32'(flap_n), 1);
         chk("glitch1_pulse", 32'(flap_pulse), 0);
      end
      $display("txn glitch 1 cycle");

      // Three-cycle glitch on sw_flap
      sw_flap = 1'b1;
      step(3);
      sw_flap = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("glitch3_flap_n", 32'(flap_n), 1);
         chk("glitch3_pulse", 32'(flap_pulse), 0);
      end
      $display("txn glitch 3 cycles");

      // Clean board press: flap_n falls 7 cycles after the pin edge
      sw_flap = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step(1);
         chk("press_flap_n", 32'(flap_n), 32'(i < 7));
         chk("press_pulse", 32'(flap_pulse), 32'(i == 7));
         chk("press_owner", 32'(owner), (i >= 7) ? 1 : 0);
      end
      $display("txn board press owner=%0d", owner);
      sw_flap = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step(1);
         chk("release_flap_n", 32'(flap_n), 32'(i >= 7));
         chk("release_owner", 32'(owner), (i >= 7) ? 0 : 1);
         chk("release_pulse", 32'(flap_pulse), 0);
      end
      $display("txn board release owner=%0d", owner);

      // Simultaneous board and pad press: board wins
      sw_flap  = 1'b1;
      pad_flap = 1'b1;
      step(7);
      chk("simul_owner", 32'(owner), 1);
      chk("simul_pulse", 32'(flap_pulse), 1);
      chk("simul_flap_n", 32'(flap_n), 0);
      $display("txn simultaneous press owner=%0d", owner);

      // Board release with pad still held: back to idle, pad ignored
      sw_flap = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         step(1);
         chk("handoff_owner", 32'(owner), (i >= 7) ? 0 : 1);
         chk("handoff_pulse", 32'(flap_pulse), 0);
      end
      $display("txn board release with pad held owner=%0d", owner);

      // Pad release then fresh re-press: pad takes ownership
      pad_flap = 1'b0;
      step(8);
      pad_flap = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step(1);
         chk("pad_owner", 32'(owner), (i >= 7) ? 2 : 0);
         chk("pad_pulse", 32'(flap_pulse), 32'(i == 7));
         chk("pad_flap_n", 32'(flap_n), 32'(i < 7));
      end
      $display("txn pad re-press owner=%0d", owner);
      pad_flap = 1'b0;
      step(7);
      chk("pad_rel_owner", 32'(owner), 0);
      chk("pad_rel_flap_n", 32'(flap_n), 1);
      step(3);

      // Pad absent: its buttons read as released
      pad_valid = 1'b0;
      pad_flap  = 1'b1;
      pad_start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step(1);
         chk("novalid_flap_n", 32'(flap_n), 1);
         chk("novalid_pending", 32'(reset_pending), 0);
         chk("novalid_owner", 32'(owner), 0);
      end
      pad_flap  = 1'b0;
      pad_start = 1'b0;
      pad_valid = 1'b1;
      step(3);
      $display("txn pad invalid: no flap, no reset");

      // Short reset hold: pending for 10 cycles, no pulse
      sw_reset = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         step(1);
         chk("short_pending", 32'(reset_pending), 32'(i >= 7 && i <= 16));
         chk("short_grn", 32'(game_reset_n), 1);
         if (i == 10) sw_reset = 1'b0;
      end
      $display("txn short reset hold, no pulse");

      // Long pad_start hold with a flap arriving during the pulse
      pad_start = 1'b1;
      for (int i = 1; i <= 55; i++) begin
         step(1);
         chk("long_grn", 32'(game_reset_n), 32'(!(i >= 23 && i <= 25)));
         chk("long_pending", 32'(reset_pending), 32'(i >= 7 && i <= 22));
         chk("long_flap_pulse", 32'(flap_pulse), 0);
         chk("long_flap_n", 32'(flap_n), 1);
         if (i == 17) sw_flap = 1'b1;
         if (i == 30) sw_flap = 1'b0;
         if (i == 40) pad_start = 1'b0;
      end
      $display("txn long hold: single pulse, flap suppressed");
      step(5);

      // sys_reset in the middle of a pulse aborts it on the next cycle
      pad_start = 1'b1;
      step(24);
      chk("abort_grn_low", 32'(game_reset_n), 0);
      sys_reset = 1'b1;
      step(1);
      chk("abort_grn", 32'(game_reset_n), 1);
      chk("abort_pending", 32'(reset_pending), 0);
      chk("abort_flap_n", 32'(flap_n), 1);
      pad_start = 1'b0;
      step(1);
      sys_reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("post_abort_grn", 32'(game_reset_n), 1);
         chk("post_abort_pending", 32'(reset_pending), 0);
      end
      $display("txn sys_reset mid-pulse");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
